dff_shift_deser: RTL and testbench

//   Serial-to-parallel deserializer built as a chain of D flip-flops.

---
 rtl/dff_shift_deser.sv | 121 ++++++++++++
 tb/tb_dff_shift_deser.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dff_shift_deser.sv
// dff_shift_deser: serial-to-parallel deserializer.
// Bits are collected in a D flip-flop shift register. Each finished WIDTH-bit
// word moves into a one-word output register that a valid/ready consumer drains.
//
// Handshakes:
//   bit side : a bit moves when bit_valid & bit_ready are both high on a rising
//              clk. bit_ready is combinational. It drops only for clear, or when
//              the completing bit would land on a held word that is not being
//              taken this cycle.
//   word side: a word moves when out_valid & out_ready are both high on a rising
//              clk. out_data holds steady while out_valid=1 and out_ready=0.
//              out_ready with out_valid=0 has no effect.
module dff_shift_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     d_in,
  input  logic                     bit_valid,
  output logic                     bit_ready,
  input  logic                     clear,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic [WIDTH-1:0] sr_shifted;
  logic             at_last;
  logic             accept;
  logic             complete;

  // Shift-register contents after one more accepted bit, in the chosen bit order.
  always_comb begin
    if (MSB_FIRST) begin
      sr_shifted = {sr_q[WIDTH-2:0], d_in};
    end else begin
      sr_shifted = {d_in, sr_q[WIDTH-1:1]};
    end
  end

  // Input acceptance. Only the completing bit waits on a held word.
  always_comb begin
    at_last   = (cnt_q == LAST_CNT);
    bit_ready = ~clear & ~(at_last & (state_q == OUT_FULL) & ~out_ready);
    accept    = bit_valid & bit_ready;
    complete  = accept & at_last;
  end

  // Next state for the partial word. clear flushes it and wins over an incoming bit.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (accept) begin
      sr_d  = sr_shifted;
      cnt_d = complete ? '0 : cnt_q + 1'b1;
    end
  end

  // Output-register FSM. A completion while full is only possible when the held
  // word is leaving in the same cycle, so the new word replaces it without a bubble.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      OUT_EMPTY: begin
        if (complete) begin
          state_d = OUT_FULL;
          data_d  = sr_shifted;
        end
      end
      OUT_FULL: begin
        if (complete) begin
          data_d = sr_shifted;
        end else if (out_ready) begin
          state_d = OUT_EMPTY;
        end
      end
      default: begin
        state_d = OUT_EMPTY;
      end
    endcase
  end

  // Register update. Reset overrides everything, including a held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == OUT_FULL);
  assign out_data  = data_q;
  assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_dff_shift_deser.sv
// Bench for dff_shift_deser. The same stimulus drives one MSB-first instance
// and one LSB-first instance. A bit-list model predicts every output.
module tb_dff_shift_deser;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst       = 1'b1;
  logic d_in      = 1'b0;
  logic bit_valid = 1'b0;
  logic clear     = 1'b0;
  logic out_ready = 1'b0;

  logic         rdy_m, rdy_l, val_m, val_l;
  logic [W-1:0] data_m, data_l;
  logic [2:0]   cnt_m, cnt_l;

  dff_shift_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .d_in(d_in), .bit_valid(bit_valid), .bit_ready(rdy_m),
    .clear(clear), .out_data(data_m), .out_valid(val_m), .out_ready(out_ready),
    .bit_cnt(cnt_m)
  );

  dff_shift_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .d_in(d_in), .bit_valid(bit_valid), .bit_ready(rdy_l),
    .clear(clear), .out_data(data_l), .out_valid(val_l), .out_ready(out_ready),
    .bit_cnt(cnt_l)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The partial word is a list of received bits. A finished word is built from
  // that list by weighting each bit with its position in the chosen order.
  bit           part[$];
  bit           model_ok  = 1'b0;
  bit           exp_valid = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_m     = '0;
  logic [W-1:0] exp_l     = '0;

  function automatic logic [W-1:0] word_of(input bit msb_first);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (part[i]) begin
        if (msb_first) w = w | (W'(1) << (W - 1 - i));
        else           w = w | (W'(1) << i);
      end
    end
    return w;
  endfunction

  function automatic bit model_ready();
    return !clear && !(part.size() == W - 1 && exp_valid && !out_ready);
  endfunction

  always @(posedge clk) begin
    bit acc;
    bit done;
    done = 1'b0;
    if (rst) begin
      part.delete();
      exp_valid = 1'b0;
      exp_m     = '0;
      exp_l     = '0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      acc = bit_valid && model_ready();
      if (clear) begin
        part.delete();
      end else if (acc) begin
        part.push_back(d_in);
        if (part.size() == W) begin
          done  = 1'b1;
          exp_m = word_of(1'b1);
          exp_l = word_of(1'b0);
          exp_q.push_back(exp_m);
          part.delete();
        end
      end
      if (done)                        exp_valid = 1'b1;
      else if (exp_valid && out_ready) exp_valid = 1'b0;
    end
  end

  // Compare every cycle, on the falling edge, once reset has been seen.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("bit_ready_m", 32'(rdy_m), 32'(model_ready()));
      chk("bit_ready_l", 32'(rdy_l), 32'(model_ready()));
      chk("out_valid_m", 32'(val_m), 32'(exp_valid));
      chk("out_valid_l", 32'(val_l), 32'(exp_valid));
      chk("out_data_m",  32'(data_m), 32'(exp_m));
      chk("out_data_l",  32'(data_l), 32'(exp_l));
      chk("bit_cnt_m",   32'(cnt_m), 32'(part.size()));
      chk("bit_cnt_l",   32'(cnt_l), 32'(part.size()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    d_in      = b;
    tick();
    bit_valid = 1'b0;
  endtask

  // Sends the top n bits of w, MSB first.
  task automatic send_bits(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[W-1-i]);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset is held for two cycles while a bit is offered.
    rst = 1'b1; bit_valid = 1'b1; d_in = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(val_m), 32'd0);
    chk("rst_data",  32'(data_m), 32'd0);
    chk("rst_cnt",   32'(cnt_m), 32'd0);
    rst = 1'b0; bit_valid = 1'b0;
    #1;
    chk("rst_ready", 32'(rdy_m), 32'd1);

    // The stream 1,0,1,1,0,0,1,0 is taken with out_ready=1.
    out_ready = 1'b1;
    send_bits(8'hB2, 8);
    chk("t2_valid",  32'(val_m), 32'd1);
    chk("t2_msb",    32'(data_m), 32'hB2);
    chk("t3_lsb",    32'(data_l), 32'h4D);
    tick();
    chk("t2_drop",   32'(val_m), 32'd0);

    // Back-pressure stalls only the completing bit.
    out_ready = 1'b0;
    send_bits(8'hA5, 8);
    chk("t4_held",   32'(data_m), 32'hA5);
    send_bits(8'h3C, 7);
    chk("t4_cnt7",   32'(cnt_m), 32'd7);
    bit_valid = 1'b1; d_in = 1'b0;
    #1;
    chk("t4_stall",  32'(rdy_m), 32'd0);
    tick();
    chk("t4_keep",   32'(data_m), 32'hA5);
    out_ready = 1'b1;
    #1;
    chk("t4_go",     32'(rdy_m), 32'd1);
    tick();
    bit_valid = 1'b0;
    chk("t4_valid",  32'(val_m), 32'd1);
    chk("t4_new",    32'(data_m), 32'h3C);
    tick();
    chk("t4_empty",  32'(val_m), 32'd0);

    // clear drops a partial word and a same-cycle bit. A held word is kept.
    out_ready = 1'b0;
    send_bits(8'h0F, 8);
    send_bits(8'hFF, 3);
    clear = 1'b1; bit_valid = 1'b1; d_in = 1'b1;
    #1;
    chk("t5_rdy0",   32'(rdy_m), 32'd0);
    tick();
    clear = 1'b0; bit_valid = 1'b0;
    chk("t5_cnt0",   32'(cnt_m), 32'd0);
    chk("t5_keep",   32'(data_m), 32'h0F);
    chk("t5_kval",   32'(val_m), 32'd1);
    out_ready = 1'b1;
    tick();
    send_bits(8'hFF, 8);
    chk("t5_ff",     32'(data_m), 32'hFF);
    tick();

    // Reset while a word is held and five bits are partial.
    out_ready = 1'b0;
    send_bits(8'h12, 8);
    send_bits(8'hFF, 5);
    chk("t6_pre",    32'(cnt_m), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid",  32'(val_m), 32'd0);
    chk("t6_cnt",    32'(cnt_m), 32'd0);
    chk("t6_data",   32'(data_m), 32'd0);

    // Mixed traffic with random valid, ready and clear patterns.
    for (int i = 0; i < 400; i++) begin
      bit_valid = ($urandom_range(0, 3) != 0);
      d_in      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 40) == 0);
      tick();
    end
    bit_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
